// File: rtl/hsid_vctr_sched_pkg.sv
// Shared types for the vector-engine scheduler: FSM state encoding and
// the job counter sizing helper.
package hsid_vctr_sched_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    LOAD,
    WAIT,
    DRAIN,
    RELEASE
  } state_t;

  // Wide enough to count 2*vl operand transfers.
  function automatic int cnt_width(input int vl);
    return $clog2(2 * vl + 1);
  endfunction

endpackage

// File: rtl/hsid_rr_arbiter.sv
// Round-robin arbiter: one-hot grant from the rotating pointer; the pointer
// moves just past the current winner when adv is pulsed.
module hsid_rr_arbiter #(
  parameter int NUM_REQ = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_REQ-1:0] req,
  input  logic               adv,
  output logic [NUM_REQ-1:0] grant
);

  localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [PW-1:0]      ptr;
  logic [NUM_REQ-1:0] masked;
  logic               found;

  // Requests at or above the pointer win first, otherwise wrap to the lowest.
  always_comb begin
    masked = '0;
    grant  = '0;
    found  = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      masked[i] = req[i] && (i >= int'(ptr));
    end
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!found && masked[i]) begin
        grant[i] = 1'b1;
        found    = 1'b1;
      end
    end
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!found && req[i]) begin
        grant[i] = 1'b1;
        found    = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr <= '0;
    end else if (adv) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (grant[i]) begin
          ptr <= (i == NUM_REQ - 1) ? '0 : PW'(i + 1);
        end
      end
    end
  end

endmodule

// File: rtl/hsid_vctr_sched.sv
// Shares one two-operand vector engine among NUM_REQ requesters: round-robin
// grant, then start / load both operands / wait / drain results per job.
module hsid_vctr_sched
  import hsid_vctr_sched_pkg::*;
#(
  parameter int DATA_WIDTH    = 16,
  parameter int VECTOR_LENGTH = 8,
  parameter int NUM_REQ       = 2
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_REQ-1:0]            req,
  output logic [NUM_REQ-1:0]            gnt,
  input  logic [NUM_REQ-1:0]            in_valid,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] in_data,
  output logic [NUM_REQ-1:0]            in_ready,
  output logic [NUM_REQ-1:0]            out_valid,
  output logic [DATA_WIDTH-1:0]         out_data,
  output logic                          out_last,
  output logic                          busy,
  output logic                          eng_start,
  output logic                          eng_data_in_en,
  output logic                          eng_data_out_en,
  output logic [DATA_WIDTH-1:0]         eng_data_in,
  input  logic                          eng_idle,
  input  logic                          eng_ready,
  input  logic                          eng_done,
  input  logic [DATA_WIDTH-1:0]         eng_data_out
);

  localparam int              CW        = cnt_width(VECTOR_LENGTH);
  localparam logic [CW-1:0]   LOAD_LAST = CW'(2 * VECTOR_LENGTH - 1);
  localparam logic [CW-1:0]   DRAIN_N   = CW'(VECTOR_LENGTH);

  state_t                state, nstate;
  logic [CW-1:0]         cnt;
  logic [NUM_REQ-1:0]    arb_req, arb_gnt;
  logic                  adv, xfer;
  logic [DATA_WIDTH-1:0] sel_data;
  logic                  vld_p1, last_p1;

  // Once a job is running the arbiter sees only the holder, so the
  // release strobe advances the pointer past the actual winner.
  assign arb_req = (state == IDLE) ? req : gnt;
  assign adv     = (state == RELEASE) && eng_idle;

  hsid_rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
    .clk   (clk),
    .rst   (rst),
    .req   (arb_req),
    .adv   (adv),
    .grant (arb_gnt)
  );

  always_comb begin
    sel_data = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (gnt[i]) sel_data = sel_data | in_data[i*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  assign xfer = (state == LOAD) && eng_ready && |(in_valid & gnt);

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= nstate;
  end

  always_comb begin
    nstate = state;
    case (state)
      IDLE:    if (|req && eng_idle)             nstate = START;
      START:                                     nstate = LOAD;
      LOAD:    if (xfer && (cnt == LOAD_LAST))   nstate = WAIT;
      WAIT:    if (eng_done)                     nstate = DRAIN;
      DRAIN:   if (cnt == DRAIN_N)               nstate = RELEASE;
      RELEASE: if (eng_idle)                     nstate = IDLE;
      default:                                   nstate = IDLE;
    endcase
  end

  always_comb begin
    busy            = (state != IDLE);
    eng_start       = (state == START);
    in_ready        = gnt & {NUM_REQ{(state == LOAD) && eng_ready}};
    eng_data_in_en  = xfer;
    eng_data_in     = xfer ? sel_data : '0;
    eng_data_out_en = (state == DRAIN) && (cnt < DRAIN_N);
  end

  // Counter restarts on every state change, so it is zero on IDLE entry.
  always_ff @(posedge clk) begin
    if (rst || (state != nstate)) cnt <= '0;
    else if (xfer || (state == DRAIN)) cnt <= cnt + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst)                                     gnt <= '0;
    else if ((state == IDLE) && (nstate == START)) gnt <= arb_gnt;
    else if (adv)                                gnt <= '0;
  end

  // Stage p1: result word returns from the engine one cycle after its issue.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p1  <= 1'b0;
      last_p1 <= 1'b0;
    end else begin
      vld_p1  <= eng_data_out_en;
      last_p1 <= eng_data_out_en && (cnt == DRAIN_N - 1'b1);
    end
  end

  assign out_valid = gnt & {NUM_REQ{vld_p1}};
  assign out_last  = last_p1;
  assign out_data  = vld_p1 ? eng_data_out : '0;

endmodule

// File: tb/tb_hsid_vctr_sched.sv
// Bench for hsid_vctr_sched with a behavioural vector engine attached;
// results and grant order come from a simple job-level reference model.
module tb_hsid_vctr_sched;

  localparam int VL = 4;
  localparam int DW = 16;
  localparam int NR = 2;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [NR-1:0]   req = '0;
  logic [NR-1:0]   gnt;
  logic [NR-1:0]   in_valid = '0;
  logic [NR*DW-1:0] in_data = '0;
  logic [NR-1:0]   in_ready;
  logic [NR-1:0]   out_valid;
  logic [DW-1:0]   out_data;
  logic            out_last, busy;
  logic            eng_start, eng_data_in_en, eng_data_out_en;
  logic [DW-1:0]   eng_data_in;
  logic            eng_idle, eng_ready, eng_done;
  logic [DW-1:0]   eng_data_out;

  hsid_vctr_sched #(.DATA_WIDTH(DW), .VECTOR_LENGTH(VL), .NUM_REQ(NR)) dut (
    .clk(clk), .rst(rst), .req(req), .gnt(gnt), .in_valid(in_valid),
    .in_data(in_data), .in_ready(in_ready), .out_valid(out_valid),
    .out_data(out_data), .out_last(out_last), .busy(busy),
    .eng_start(eng_start), .eng_data_in_en(eng_data_in_en),
    .eng_data_out_en(eng_data_out_en), .eng_data_in(eng_data_in),
    .eng_idle(eng_idle), .eng_ready(eng_ready), .eng_done(eng_done),
    .eng_data_out(eng_data_out)
  );

  always #5 clk = ~clk;

  // Behavioural engine: A/B FIFOs, fixed compute latency, registered output.
  logic [DW-1:0] ea [VL];
  logic [DW-1:0] eb [VL];
  int   e_in, e_out, e_lat;
  logic e_idle, eng_hold = 1'b0;

  always @(posedge clk) begin
    if (rst) begin
      e_idle <= 1'b1; eng_ready <= 1'b0; eng_done <= 1'b0; eng_data_out <= '0;
      e_in <= 0; e_out <= 0; e_lat <= 0;
    end else begin
      if (eng_start) begin
        e_idle <= 1'b0; eng_ready <= 1'b1; e_in <= 0; e_out <= 0;
      end
      if (eng_data_in_en && eng_ready) begin
        if (e_in < VL) ea[e_in] <= eng_data_in;
        else           eb[e_in-VL] <= eng_data_in;
        e_in <= e_in + 1;
        if (e_in == 2*VL-1) begin eng_ready <= 1'b0; e_lat <= 3; end
      end
      if (e_lat > 0) begin
        e_lat <= e_lat - 1;
        if (e_lat == 1) eng_done <= 1'b1;
      end
      if (eng_data_out_en) begin
        eng_data_out <= ea[e_out] + eb[e_out];
        e_out <= e_out + 1;
        eng_done <= 1'b0;
        if (e_out == VL-1) e_idle <= 1'b1;
      end
    end
  end
  assign eng_idle = e_idle && !eng_hold;

  int checks = 0;
  int errors = 0;

  task automatic chk_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, act, exp);
    end
  endtask

  // Requester-side state and reference model.
  logic [DW-1:0] wd [NR][2*VL];
  logic [DW-1:0] expv [VL];
  int  xi [NR];
  int  gp [NR];
  int  gap_mode [NR];
  bit  pend [NR];
  bit  drop [NR];
  int  ptr_m = 0;
  int  cur = -1;
  int  cyc = 0;
  int  oc, xfers, done_cyc, first_cyc, last_cyc, jobs_done;

  function automatic logic [NR-1:0] rr_pick(input logic [NR-1:0] r, input int p);
    for (int k = 0; k < NR; k++) begin
      int i;
      i = (p + k) % NR;
      if (r[i]) return NR'(1) << i;
    end
    return '0;
  endfunction

  task automatic setup_rand(input int r, input int mode);
    for (int i = 0; i < 2*VL; i++) wd[r][i] = DW'($urandom);
    xi[r] = 0; gp[r] = 0; gap_mode[r] = mode; drop[r] = 1'b0; pend[r] = 1'b1;
  endtask

  task automatic run(input int jobs, input int abort_after);
    int budget;
    logic [NR-1:0] xf;
    budget = 150 * jobs;
    jobs_done = 0;
    forever begin
      @(negedge clk);
      cyc++;
      chk_eq("ready_only_granted", in_ready & ~gnt, 0);
      if (cur < 0 && gnt != 0) begin
        chk_eq("grant", gnt, rr_pick(req, ptr_m));
        chk_eq("start_pulse", eng_start, 1);
        cur = gnt[1] ? 1 : 0;
        for (int i = 0; i < VL; i++) expv[i] = DW'(wd[cur][i] + wd[cur][i+VL]);
        oc = 0; xfers = 0; done_cyc = -1; first_cyc = -1; last_cyc = -1;
      end
      if (cur >= 0 && eng_done && done_cyc < 0) done_cyc = cyc;
      if (out_valid != 0) begin
        chk_eq("out_valid_onehot", out_valid, gnt);
        if (cur >= 0 && oc < VL) begin
          chk_eq("out_data", out_data, expv[oc]);
          chk_eq("out_last", out_last, (oc == VL-1));
          if (oc == 0) begin
            first_cyc = cyc;
            chk_eq("drain_latency", cyc - done_cyc, 2);
          end
        end
        last_cyc = cyc;
        oc++;
      end
      if (cur >= 0 && gnt == 0) begin
        chk_eq("words_out", oc, VL);
        chk_eq("transfers", xfers, 2*VL);
        chk_eq("busy_end", busy, 0);
        chk_eq("drain_b2b", last_cyc - first_cyc, VL-1);
        ptr_m = (cur + 1) % NR;
        pend[cur] = 1'b0; req[cur] = 1'b0; in_valid[cur] = 1'b0;
        cur = -1;
        jobs_done++;
        if (jobs_done == jobs) break;
      end
      for (int r = 0; r < NR; r++) begin
        bit v;
        req[r] = pend[r] && !(drop[r] && cur == r && xfers > 0);
        case (gap_mode[r])
          1:       v = (gp[r] % 3 == 0);
          2:       v = ($urandom_range(0, 2) != 0);
          default: v = 1'b1;
        endcase
        if (cur == r) gp[r]++;
        in_valid[r] = (cur == r) && (xi[r] < 2*VL) && v;
        if (xi[r] < 2*VL) in_data[r*DW +: DW] = wd[r][xi[r]];
      end
      #1;
      xf = in_valid & in_ready;
      chk_eq("din_en", eng_data_in_en, |xf);
      if (cur >= 0 && xf[cur]) begin
        chk_eq("din", eng_data_in, wd[cur][xi[cur]]);
        xi[cur]++;
        xfers++;
      end
      if (abort_after > 0 && xfers == abort_after) break;
      budget--;
      if (budget == 0) begin
        chk_eq("timeout", 0, 1);
        break;
      end
    end
  endtask

  task automatic chk_quiet(input string tag);
    chk_eq({tag, "_gnt"}, gnt, 0);
    chk_eq({tag, "_busy"}, busy, 0);
    chk_eq({tag, "_out_valid"}, out_valid, 0);
    chk_eq({tag, "_out_last"}, out_last, 0);
    chk_eq({tag, "_out_data"}, out_data, 0);
    chk_eq({tag, "_in_ready"}, in_ready, 0);
    chk_eq({tag, "_ctl"}, {eng_start, eng_data_in_en, eng_data_out_en}, 0);
  endtask

  initial begin
    for (int r = 0; r < NR; r++) begin
      pend[r] = 0; drop[r] = 0; gap_mode[r] = 0; xi[r] = 0; gp[r] = 0;
    end
    repeat (3) @(negedge clk);
    chk_quiet("reset");
    rst = 1'b0;

    // Single job with known operands.
    setup_rand(0, 0);
    for (int i = 0; i < VL; i++) begin
      wd[0][i] = DW'(i + 1);
      wd[0][i+VL] = DW'(10 * (i + 1));
    end
    run(1, 0);
    chk_eq("single_sum0", 32'(expv[0]), 11);
    chk_eq("single_sum3", 32'(expv[3]), 44);

    // Contention, twice.
    setup_rand(0, 0); setup_rand(1, 0); run(2, 0);
    setup_rand(1, 0); run(1, 0);
    setup_rand(0, 0); setup_rand(1, 0); run(2, 0);

    // Input gaps 1,0,0 repeating.
    setup_rand(0, 1); run(1, 0);

    // Wrap-around.
    setup_rand(0, 0);
    for (int i = 0; i < VL; i++) begin wd[0][i] = 16'hFFFF; wd[0][i+VL] = 16'h0002; end
    run(1, 0);
    chk_eq("wrap_sum", 32'(expv[0]), 1);

    // Request dropped during LOAD.
    setup_rand(1, 0); drop[1] = 1'b1; run(1, 0);

    // Engine still busy: no grant.
    eng_hold = 1'b1;
    setup_rand(0, 0); req[0] = 1'b1;
    repeat (6) @(negedge clk);
    chk_eq("hold_no_gnt", gnt, 0);
    chk_eq("hold_not_busy", busy, 0);
    eng_hold = 1'b0;
    run(1, 0);

    // Reset mid-LOAD after three words.
    setup_rand(0, 0); run(1, 3);
    @(posedge clk); #1;
    rst = 1'b1; in_valid = '0; req = '0;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk_quiet("midreset");
    cur = -1; ptr_m = 0;
    for (int r = 0; r < NR; r++) pend[r] = 0;
    setup_rand(1, 0); setup_rand(0, 0); run(2, 0);

    // Randomized job mixes.
    repeat (12) begin
      int m, n;
      m = $urandom_range(1, 3);
      n = 0;
      for (int r = 0; r < NR; r++) begin
        if (m[r]) begin
          setup_rand(r, $urandom_range(0, 2));
          drop[r] = bit'($urandom_range(0, 1));
          n++;
        end
      end
      run(n, 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog got=running exp=finished");
    $fatal(1, "watchdog");
  end

endmodule
